// File: rtl/reg_transfer_arbiter.sv
// -----------------------------------------------------------------------------
// reg_transfer_arbiter
//
// Sequencer and two-port round-robin arbiter for a bank of 8-bit working
// registers that share one 8-bit bus. Each register is a pair of 74173-style
// 4-bit D-registers whose output enable (M/N) and load enable (G1_n) are driven
// from OE_n / LD_n below. A granted transfer walks GRANT -> DRIVE -> LOAD ->
// RELEASE, so the source drives the bus for SETTLE cycles before the
// destination is strobed, and at most one register ever drives the bus.
//
// Parameters
//   NREG    number of registers on the bus (2..8), indices are 3 bits
//   SETTLE  bus-settle cycles with the source driving before the load (0..7)
//
// Ports
//   CLK         clock, all state changes on the rising edge
//   CLR_n       asynchronous active-low reset
//   REQ[1:0]    level transfer request per port (0: control unit, 1: loader)
//   SRC0/DST0   port 0 source / destination register index
//   SRC1/DST1   port 1 source / destination register index
//   GNT[1:0]    one-hot grant, GRANT through RELEASE
//   DONE[1:0]   one-cycle completion pulse for the served port
//   ERR         one-cycle pulse with DONE when the request was illegal
//   BUSY        high whenever the sequencer is not idle
//   OE_n        per-register output enable, active-low
//   LD_n        per-register load enable, active-low
// All outputs are registered; nothing combinational reaches a port.
// -----------------------------------------------------------------------------
module reg_transfer_arbiter #(
  parameter int NREG   = 8,
  parameter int SETTLE = 1
) (
  input  logic            CLK,
  input  logic            CLR_n,
  input  logic [1:0]      REQ,
  input  logic [2:0]      SRC0,
  input  logic [2:0]      DST0,
  input  logic [2:0]      SRC1,
  input  logic [2:0]      DST1,
  output logic [1:0]      GNT,
  output logic [1:0]      DONE,
  output logic            ERR,
  output logic            BUSY,
  output logic [NREG-1:0] OE_n,
  output logic [NREG-1:0] LD_n
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_DRIVE,
    S_LOAD,
    S_RELEASE
  } state_e;

  // Register count widened so a 3-bit index can be range-checked against it.
  localparam logic [3:0] NREG_W      = 4'(NREG);
  // Value of the settle counter in the last DRIVE cycle.
  localparam logic [2:0] SETTLE_LAST = (SETTLE == 0) ? 3'd0 : 3'(SETTLE - 1);

  // Sequencer state
  state_e          state_q,   state_d;
  logic [2:0]      cnt_q,     cnt_d;
  logic            last_q,    last_d;     // port served most recently
  logic            win_q,     win_d;      // port currently being served
  logic [2:0]      src_q,     src_d;
  logic [2:0]      dst_q,     dst_d;
  logic            illegal_q, illegal_d;

  // Registered outputs
  logic [1:0]      gnt_q,     gnt_d;
  logic [1:0]      done_q,    done_d;
  logic            err_q,     err_d;
  logic            busy_q,    busy_d;
  logic [NREG-1:0] oe_n_q,    oe_n_d;
  logic [NREG-1:0] ld_n_q,    ld_n_d;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    win_d     = win_q;
    src_d     = src_q;
    dst_d     = dst_q;
    illegal_d = illegal_q;

    unique case (state_q)
      S_IDLE: begin
        if (REQ != 2'b00) begin
          // Under contention the port not served last wins; a lone request
          // wins outright regardless of the pointer.
          win_d   = (REQ == 2'b11) ? ~last_q : REQ[1];
          state_d = S_GRANT;
        end
      end

      S_GRANT: begin
        // The indices are captured here; later changes on SRC/DST are ignored.
        src_d     = win_q ? SRC1 : SRC0;
        dst_d     = win_q ? DST1 : DST0;
        illegal_d = ({1'b0, src_d} >= NREG_W) || ({1'b0, dst_d} >= NREG_W) ||
                    (src_d == dst_d);
        cnt_d     = 3'd0;
        if (illegal_d) begin
          state_d = S_RELEASE;
        end else if (SETTLE == 0) begin
          state_d = S_LOAD;
        end else begin
          state_d = S_DRIVE;
        end
      end

      S_DRIVE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = 3'd0;
          state_d = S_LOAD;
        end else begin
          cnt_d   = cnt_q + 3'd1;
        end
      end

      S_LOAD: begin
        state_d = S_RELEASE;
      end

      S_RELEASE: begin
        last_d  = win_q;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode from the next state, so every port comes straight off a flop
  // and lines up with the state it belongs to.
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_d = (state_d != S_IDLE);
    gnt_d  = 2'b00;
    done_d = 2'b00;
    err_d  = 1'b0;
    oe_n_d = '1;
    ld_n_d = '1;

    if (state_d != S_IDLE) begin
      gnt_d = win_d ? 2'b10 : 2'b01;
    end

    if (state_d == S_RELEASE) begin
      done_d = gnt_d;
      err_d  = illegal_d;
    end

    // Strobes only exist in DRIVE/LOAD, which an illegal request never
    // reaches, so both indices are in range whenever they are decoded.
    for (int i = 0; i < NREG; i++) begin
      if ((state_d == S_DRIVE || state_d == S_LOAD) && (src_d == 3'(i))) begin
        oe_n_d[i] = 1'b0;
      end
      if ((state_d == S_LOAD) && (dst_d == 3'(i))) begin
        ld_n_d[i] = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      // NOTE: every flop here is reset, including the latched indices, so a
      // transfer caught mid-flight leaves nothing behind and the strobes go
      // inactive the instant CLR_n falls.
      state_q   <= S_IDLE;
      cnt_q     <= 3'd0;
      last_q    <= 1'b1;
      win_q     <= 1'b0;
      src_q     <= 3'd0;
      dst_q     <= 3'd0;
      illegal_q <= 1'b0;
      gnt_q     <= 2'b00;
      done_q    <= 2'b00;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      oe_n_q    <= '1;
      ld_n_q    <= '1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      win_q     <= win_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      illegal_q <= illegal_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      oe_n_q    <= oe_n_d;
      ld_n_q    <= ld_n_d;
    end
  end

  assign GNT  = gnt_q;
  assign DONE = done_q;
  assign ERR  = err_q;
  assign BUSY = busy_q;
  assign OE_n = oe_n_q;
  assign LD_n = ld_n_q;

endmodule

// File: tb/tb_reg_transfer_arbiter.sv
// -----------------------------------------------------------------------------
// tb_reg_transfer_arbiter
//
// Directed bench for reg_transfer_arbiter. Three instances share the request
// inputs: the main one (NREG=8, SETTLE=1) drives a behavioural model of the
// register bank, one with NREG=4/SETTLE=0 and one with SETTLE=7 cover the
// parameter boundaries. Cycle numbering follows the datasheet: cycle 0 is the
// IDLE cycle in which REQ is first seen.
// -----------------------------------------------------------------------------
module tb_reg_transfer_arbiter;

  logic       CLK;
  logic       CLR_n;
  logic [1:0] REQ;
  logic [2:0] SRC0, DST0, SRC1, DST1;

  // Main instance
  logic [1:0] GNT, DONE;
  logic       ERR, BUSY;
  logic [7:0] OE_n, LD_n;

  // NREG = 4, SETTLE = 0
  logic [1:0] gnt_a, done_a;
  logic       err_a, busy_a;
  logic [3:0] oe_n_a, ld_n_a;

  // NREG = 8, SETTLE = 7
  logic [1:0] gnt_b, done_b;
  logic       err_b, busy_b;
  logic [7:0] oe_n_b, ld_n_b;

  int tests_run    = 0;
  int tests_failed = 0;

  logic       preload;
  logic [7:0] bank     [8];
  logic [7:0] exp_bank [8];

  reg_transfer_arbiter #(.NREG(8), .SETTLE(1)) dut (
    .CLK(CLK), .CLR_n(CLR_n), .REQ(REQ),
    .SRC0(SRC0), .DST0(DST0), .SRC1(SRC1), .DST1(DST1),
    .GNT(GNT), .DONE(DONE), .ERR(ERR), .BUSY(BUSY), .OE_n(OE_n), .LD_n(LD_n)
  );

  reg_transfer_arbiter #(.NREG(4), .SETTLE(0)) dut_a (
    .CLK(CLK), .CLR_n(CLR_n), .REQ(REQ),
    .SRC0(SRC0), .DST0(DST0), .SRC1(SRC1), .DST1(DST1),
    .GNT(gnt_a), .DONE(done_a), .ERR(err_a), .BUSY(busy_a),
    .OE_n(oe_n_a), .LD_n(ld_n_a)
  );

  reg_transfer_arbiter #(.NREG(8), .SETTLE(7)) dut_b (
    .CLK(CLK), .CLR_n(CLR_n), .REQ(REQ),
    .SRC0(SRC0), .DST0(DST0), .SRC1(SRC1), .DST1(DST1),
    .GNT(gnt_b), .DONE(done_b), .ERR(err_b), .BUSY(busy_b),
    .OE_n(oe_n_b), .LD_n(ld_n_b)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Register bank on the shared bus, strobed by the main instance.
  always @(posedge CLK) begin
    logic [7:0] bus;
    bus = 8'h00;
    for (int i = 0; i < 8; i++) if (!OE_n[i]) bus = bank[i];
    for (int i = 0; i < 8; i++) begin
      if (preload)       bank[i] <= 8'(8'h11 * (i + 1));
      else if (!LD_n[i]) bank[i] <= bus;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bus invariants on the main instance, every cycle, away from the edge.
  always @(negedge CLK) begin
    logic [5:0] viol;
    viol = {!$onehot0(~OE_n), !$onehot0(~LD_n), |(~OE_n & ~LD_n),
            !$onehot0(GNT), |(DONE & ~GNT), (LD_n != 8'hFF) && !BUSY};
    check("invariants", 32'(viol), 32'd0);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // which = 0: wait for a grant, 1: wait for DONE. Bounded by limit cycles.
  task automatic wait_for(input string tag, input int which, input int limit);
    int n = 0;
    do begin
      tick();
      n++;
    end while (((which == 0) ? (GNT == 2'b00) : (DONE == 2'b00)) && n < limit);
    if ((which == 0) ? (GNT == 2'b00) : (DONE == 2'b00))
      check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic reset_pulse();
    CLR_n = 1'b0;
    tick();
    CLR_n = 1'b1;
    tick();
  endtask

  logic [2:0] s_idx [2];
  logic [2:0] d_idx [2];
  int         wait_cnt [2];

  initial begin
    CLR_n   = 1'b0;
    preload = 1'b1;
    REQ     = 2'b11;
    SRC0 = 3'd0; DST0 = 3'd1; SRC1 = 3'd2; DST1 = 3'd3;
    for (int i = 0; i < 8; i++) exp_bank[i] = 8'(8'h11 * (i + 1));

    // ---- Reset held with both requests up ----
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rst_oe", 32'(OE_n), 32'hFF);
      check("rst_ld", 32'(LD_n), 32'hFF);
      check("rst_flags", {26'd0, GNT, DONE, ERR, BUSY}, 32'd0);
    end
    preload = 1'b0;
    REQ     = 2'b00;
    CLR_n   = 1'b1;
    tick();

    // ---- Single legal transfer 2 -> 5 on port 0 ----
    REQ = 2'b01; SRC0 = 3'd2; DST0 = 3'd5;
    check("t1_c0_gnt", 32'(GNT), 32'd0);
    tick();
    check("t1_c1_gnt", 32'(GNT), 32'h1);
    check("t1_c1_oe", 32'(OE_n), 32'hFF);
    check("t1_c1_busy", 32'(BUSY), 32'd1);
    tick();
    check("t1_c2_oe", 32'(OE_n), 32'hFB);
    check("t1_c2_ld", 32'(LD_n), 32'hFF);
    tick();
    check("t1_c3_oe", 32'(OE_n), 32'hFB);
    check("t1_c3_ld", 32'(LD_n), 32'hDF);
    check("t1_c3_done", 32'(DONE), 32'd0);
    tick();
    check("t1_c4_done", 32'(DONE), 32'h1);
    check("t1_c4_gnt", 32'(GNT), 32'h1);
    check("t1_c4_strobes", {16'd0, OE_n, LD_n}, 32'hFFFF);
    check("t1_c4_err", 32'(ERR), 32'd0);
    REQ = 2'b00;
    exp_bank[5] = exp_bank[2];
    check("t1_bank5", 32'(bank[5]), 32'h33);
    tick();
    check("t1_c5_idle", {30'd0, DONE == 2'b00, BUSY}, 32'h2);

    // ---- Illegal: port 1 with SRC == DST ----
    REQ = 2'b10; SRC1 = 3'd3; DST1 = 3'd3;
    tick();
    check("ill_c1_gnt", 32'(GNT), 32'h2);
    check("ill_c1_oe", 32'(OE_n), 32'hFF);
    tick();
    check("ill_c2_done", 32'(DONE), 32'h2);
    check("ill_c2_err", 32'(ERR), 32'd1);
    check("ill_c2_strobes", {16'd0, OE_n, LD_n}, 32'hFFFF);
    REQ = 2'b00;
    tick();
    check("ill_c3_err", {30'd0, ERR, BUSY}, 32'd0);

    // ---- Indices changed during DRIVE are ignored (6 -> 7) ----
    REQ = 2'b01; SRC0 = 3'd6; DST0 = 3'd7;
    tick();
    tick();
    check("lat_c2_oe", 32'(OE_n), 32'hBF);
    SRC0 = 3'd0; DST0 = 3'd0;
    tick();
    check("lat_c3_oe", 32'(OE_n), 32'hBF);
    check("lat_c3_ld", 32'(LD_n), 32'h7F);
    tick();
    check("lat_c4_done", 32'(DONE), 32'h1);
    REQ = 2'b00;
    exp_bank[7] = exp_bank[6];
    check("lat_bank7", 32'(bank[7]), 32'(exp_bank[7]));
    tick();

    // ---- Contention from reset: grants alternate 0,1,0,1 ----
    reset_pulse();
    REQ = 2'b11; SRC0 = 3'd0; DST0 = 3'd1; SRC1 = 3'd2; DST1 = 3'd3;
    for (int k = 0; k < 4; k++) begin
      wait_for("rr_gnt", 0, 10);
      check("rr_gnt", 32'(GNT), (k % 2 == 0) ? 32'h1 : 32'h2);
      wait_for("rr_done", 1, 10);
      check("rr_done", 32'(DONE), (k % 2 == 0) ? 32'h1 : 32'h2);
    end
    REQ = 2'b00;
    exp_bank[1] = exp_bank[0];
    exp_bank[3] = exp_bank[2];
    check("rr_bank1", 32'(bank[1]), 32'(exp_bank[1]));
    check("rr_bank3", 32'(bank[3]), 32'(exp_bank[3]));
    tick();

    // ---- Reset asserted mid-DRIVE ----
    REQ = 2'b01; SRC0 = 3'd3; DST0 = 3'd4;
    tick();
    tick();
    check("mid_c2_oe", 32'(OE_n), 32'hF7);
    #2 CLR_n = 1'b0;
    #1;
    check("mid_rst_oe", 32'(OE_n), 32'hFF);
    check("mid_rst_flags", {28'd0, GNT, BUSY, ERR}, 32'd0);
    REQ = 2'b00;
    tick();
    CLR_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("mid_no_done", {30'd0, DONE == 2'b00, BUSY}, 32'h2);
    end
    check("mid_bank4", 32'(bank[4]), 32'(exp_bank[4]));

    // ---- NREG = 4 instance: DST0 = 6 out of range (legal on main: 1 -> 6) ----
    REQ = 2'b01; SRC0 = 3'd1; DST0 = 3'd6;
    tick();
    check("n4_c1_gnt", 32'(gnt_a), 32'h1);
    tick();
    check("n4_c2_done", 32'(done_a), 32'h1);
    check("n4_c2_err", 32'(err_a), 32'd1);
    check("n4_c2_strobes", {24'd0, oe_n_a, ld_n_a}, 32'hFF);
    REQ = 2'b00;
    tick();
    tick();
    // Main instance completes even though REQ fell after GRANT.
    check("drop_c4_done", 32'(DONE), 32'h1);
    exp_bank[6] = exp_bank[1];
    check("drop_bank6", 32'(bank[6]), 32'(exp_bank[6]));
    tick();
    reset_pulse();

    // ---- SETTLE = 0 and SETTLE = 7 timing, transfer 1 -> 2 ----
    REQ = 2'b01; SRC0 = 3'd1; DST0 = 3'd2;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 2) begin
        check("s0_c2_ld", 32'(ld_n_a), 32'hB);
        check("s0_c2_oe", 32'(oe_n_a), 32'hD);
      end
      if (c == 3) check("s0_c3_done", 32'(done_a), 32'h1);
      if (c == 8) check("s7_c8_ld", 32'(ld_n_b), 32'hFF);
      if (c == 9) begin
        check("s7_c9_ld", 32'(ld_n_b), 32'hFB);
        check("s7_c9_oe", 32'(oe_n_b), 32'hFD);
        check("s7_c9_done", 32'(done_b), 32'd0);
      end
      if (c == 10) check("s7_c10_done", 32'(done_b), 32'h1);
    end
    REQ = 2'b00;
    exp_bank[2] = exp_bank[1];
    tick();
    tick();

    // ---- Random stress on the main instance ----
    for (int p = 0; p < 2; p++) wait_cnt[p] = 0;
    for (int cyc = 0; cyc < 10040; cyc++) begin
      for (int p = 0; p < 2; p++) begin
        if (DONE[p]) begin
          check("st_done_req", 32'(REQ[p]), 32'd1);
          check("st_err", 32'(ERR), 32'(s_idx[p] == d_idx[p]));
          check("st_latency", 32'(wait_cnt[p] <= 16), 32'd1);
          if (s_idx[p] != d_idx[p]) begin
            exp_bank[d_idx[p]] = exp_bank[s_idx[p]];
            check("st_bank", 32'(bank[d_idx[p]]), 32'(exp_bank[d_idx[p]]));
          end
          REQ[p] = 1'b0;
        end else if (REQ[p]) begin
          wait_cnt[p]++;
        end else if (cyc < 10000 && $urandom_range(2) == 0) begin
          s_idx[p]    = 3'($urandom_range(7));
          d_idx[p]    = 3'($urandom_range(7));
          wait_cnt[p] = 0;
          if (p == 0) begin SRC0 = s_idx[p]; DST0 = d_idx[p]; end
          else        begin SRC1 = s_idx[p]; DST1 = d_idx[p]; end
          REQ[p] = 1'b1;
        end
      end
      tick();
    end
    check("st_drained", {30'd0, REQ}, 32'd0);
    for (int i = 0; i < 8; i++) check("st_final_bank", 32'(bank[i]), 32'(exp_bank[i]));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/reg_transfer_arbiter.md
# reg_transfer_arbiter

Sequencer and two-port arbiter for the CPU's bank of 8-bit working registers. Each register is a pair of 4-bit 74173-style D-registers on the shared 8-bit bus. The block accepts register-to-register transfer requests from two requesters (port 0: control unit, port 1: program loader/debug). It grants one requester at a time, round-robin. For the granted transfer it drives the per-register active-low output-enable and load-enable strobes in a fixed drive/settle/load sequence, so at most one register ever drives the bus.

## Interface
Parameters:
- NREG, 8: number of 8-bit registers on the bus (2..8); indices are 3 bits.
- SETTLE, 1: bus-settle cycles with the source driving before the load strobe (0..7).

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- CLR_n  in  1  reset, asynchronous, active-low.
- REQ  in  2  per-port transfer request, level; bit i = port i.
- SRC0, DST0  in  3 each  port 0 source / destination register index.
- SRC1, DST1  in  3 each  port 1 source / destination register index.
- GNT  out  2  one-hot grant; high from GRANT through RELEASE for the served port.
- DONE  out  2  one-cycle completion pulse for the served port.
- ERR  out  1  one-cycle pulse, coincident with DONE, on an illegal request.
- BUSY  out  1  high whenever state is not IDLE.
- OE_n  out  NREG  per-register output enable, active-low; wired to both M and N of the register pair.
- LD_n  out  NREG  per-register load enable, active-low; wired to G1_n (G2_n tied low).

## Operation
- States: IDLE, GRANT, DRIVE, LOAD, RELEASE.
- IDLE: REQ is sampled only here.
  - If any REQ bit is set, pick a winner: single request wins outright; if both are set, the port not served last wins.
  - Last-served pointer resets to port 1, so port 0 wins the first contention.
  - Go to GRANT.
- GRANT: latch the winner's SRC/DST into internal registers and assert GNT[winner].
  - Illegal request (SRC or DST ≥ NREG, or SRC == DST): go to RELEASE with ERR set and no strobe ever asserted.
  - Otherwise go to DRIVE, or straight to LOAD if SETTLE = 0.
- DRIVE: OE_n[src] low; count SETTLE cycles, then go to LOAD.
- LOAD: exactly one cycle. OE_n[src] and LD_n[dst] both low; the destination captures the bus at the rising edge ending this cycle. Go to RELEASE.
- RELEASE: all OE_n/LD_n high; DONE[winner] = 1, plus ERR if illegal. Update the last-served pointer. Go to IDLE.
- SRC/DST changes after GRANT are ignored (latched copy used). Dropping REQ after GRANT does not abort; the transfer completes.
- Requesters drop REQ on DONE. A REQ still high in the IDLE cycle after DONE is treated as a new request.
- Invariants, all cycles:
  - At most one OE_n bit low.
  - At most one LD_n bit low, and only in LOAD.
  - LD_n[x] and OE_n[x] are never both low for the same x.
  - GNT at most one-hot; DONE implies matching GNT.
- Reset: all outputs take their reset values immediately on CLR_n low, independent of CLK. Any in-flight transfer is abandoned with no DONE; state returns to IDLE.

## Timing
- Reset values: OE_n = all ones, LD_n = all ones, GNT = 0, DONE = 0, ERR = 0, BUSY = 0; state IDLE; SETTLE counter 0; pointer = port 1.
- All outputs are registered (Moore); no combinational path from REQ/SRC/DST to any output.
- Legal transfer, REQ seen in IDLE at cycle 0:
  - GRANT: cycle 1.
  - DRIVE: cycles 2..1+SETTLE.
  - LOAD: cycle 2+SETTLE.
  - DONE: cycle 3+SETTLE.
  - IDLE: cycle 4+SETTLE.
  - With SETTLE = 1: DONE at cycle 4; next grant no earlier than cycle 6.
- Illegal transfer: GRANT at cycle 1, RELEASE (DONE + ERR) at cycle 2.
- Minimum one IDLE cycle between transfers; throughput one transfer per SETTLE+4 cycles.

## Test plan
- Reset: hold CLR_n low for 3 cycles with REQ = 2'b11 → OE_n = LD_n = 8'hFF, GNT = DONE = ERR = BUSY = 0 throughout. CLR_n asserted mid-DRIVE → OE_n = 8'hFF before the next edge; no DONE follows.
- Single transfer, SETTLE = 1: REQ = 2'b01, SRC0 = 2, DST0 = 5 at cycle 0 → GNT = 01 cycles 1-4; OE_n = 8'hFB cycles 2-3; LD_n = 8'hDF cycle 3 only; DONE = 01 cycle 4; register 5 holds register 2's value after cycle 3.
- Contention: REQ = 2'b11 held → grants alternate 0, 1, 0, 1; each DONE matches its GNT; never two OE_n bits low at once.
- Illegal: SRC1 = DST1 = 3 → DONE = 10 and ERR = 1 at cycle 2; OE_n/LD_n stay 8'hFF. Repeat with NREG = 4 and DST0 = 6 → same ERR behaviour.
- SETTLE = 0 and SETTLE = 7: LOAD at cycles 2 and 9, DONE at 3 and 10. SRC changed during DRIVE → strobes follow the latched index.
- Random stress, 10k cycles, both ports, random indices: scoreboard destination contents and check all invariants every cycle.
